prescaled_scan_counter: RTL and testbench
=========================================

PRESCALED_SCAN_COUNTER -- requirements
Module: prescaled_scan_counter

Interface
REQ-001 Parameter PRE_W, default 20: prescaler width in bits.
REQ-002 Parameter CNT_W, default 3: scan count width in bits; NSEL = 2**CNT_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  advance enable; 0 freezes the prescaler and the count.
REQ-006 div  input  PRE_W  prescaler terminal value; one tick every div+1 enabled cycles.
REQ-007 max  input  CNT_W  count terminal value; count range 0..max.
REQ-008 up  input  1  direction: 1 counts up, 0 counts down.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  CNT_W  value written to count on load.
REQ-011 count  output  CNT_W  registered scan count.
REQ-012 tick  output  1  registered one-cycle pulse, high on the cycle count advances.
REQ-013 wrap  output  1  registered one-cycle pulse, high on the cycle count wraps.
REQ-014 sel  output  NSEL  one-hot decode of count: sel[count]=1, all other bits 0.

Function
REQ-015 Prescaler register pre (PRE_W bits) increments each en=1 cycle; when pre>=div it returns to 0 on the next edge and that edge raises tick.
REQ-016 The pre>=div comparison (not equality) applies, so a div lowered below pre mid-run produces a tick on the next enabled edge with no long overflow.
REQ-017 div=0: tick every enabled cycle, count advances every cycle.
REQ-018 count updates on the same edge that raises tick; latency from the terminal prescaler cycle to the new count is exactly one clock.
REQ-019 Up step: if count>=max then count<=0 and wrap=1, else count<=count+1.
REQ-020 Down step: if count==0 then count<=max and wrap=1; else if count>max then count<=max with wrap=0; else count<=count-1.
REQ-021 max=0: count stays 0; every tick also raises wrap.
REQ-022 tick and wrap are 0 on every cycle with no advance; they never stay high two consecutive cycles unless a tick occurs on each of those cycles.
REQ-023 en=0: pre and count hold; tick=0, wrap=0.
REQ-024 load=1, independent of en: count<=(load_val>max ? max : load_val), pre<=0, tick=0, wrap=0; load overrides a simultaneous tick.
REQ-025 Changing up or max takes effect at the next tick; no state is corrupted.
REQ-026 sel is a combinational decode of the count register only; it is glitch-free relative to clk and has exactly one bit set at all times.

Reset
REQ-027 rst=1 asynchronously forces pre=0, count=0, tick=0, wrap=0, and therefore sel=1 (bit 0).
REQ-028 Release of rst: the first prescaler increment occurs on the first rising edge with rst=0 and en=1; the first tick follows div+1 enabled edges later.
REQ-029 rst asserted mid-count aborts the current prescale period; no partial tick or wrap pulse is emitted.

Structure
REQ-030 No shared package is required; PRE_W and CNT_W are module parameters and NSEL is a localparam.
REQ-031 The prescaler (pre, comparison, tick generation, en, load-clear) is a sub-module named tick_prescaler (parameter PRE_W; ports clk, rst, en, clr, div, tick).
REQ-032 The count/wrap/load logic and the sel decoder reside in prescaled_scan_counter.

Verification (PRE_W=5, CNT_W=3 unless stated)
REQ-033 div=3, max=7, up=1, en=1 from reset -> tick every 4 cycles; count runs 0..7, then 0 with wrap=1; sel tracks 8'h01..8'h80.
REQ-034 div=0, max=4, up=0 -> count 0,4,3,2,1,0,4 on consecutive cycles; wrap high on each 0->4 step.
REQ-035 Count at 6, then max lowered to 2, up=1 -> next tick gives count=0, wrap=1; up=0 instead -> count=2, wrap=0.
REQ-036 load=1, load_val=5, max=3, on the same cycle as a pending tick -> count=3, tick=0, pre=0; the next tick occurs div+1 enabled cycles later.
REQ-037 en deasserted for 10 cycles mid-period -> pre and count frozen, no tick; the period resumes with the remaining cycles after en=1.
REQ-038 rst pulsed between clock edges at count=5 -> count=0 and sel=8'h01 immediately without a clock edge; defaults PRE_W=20, CNT_W=3, div=2**20-1 -> first tick 2**20 enabled cycles after release.

Source files
------------

// File: rtl/prescaled_scan_counter_pkg.sv
// Shared types for the prescaled scan counter.
//
// step_e names the four things that can happen to the scan count on a
// clock edge. The top module picks one step per cycle and the count/wrap
// logic acts on it. Keeping the choice as a named value makes the
// priority (load over advance over hold) explicit in one place.
package prescaled_scan_counter_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_LOAD = 2'd3
  } step_e;

endpackage

// File: rtl/prescaled_scan_counter_tick_prescaler.sv
// tick_prescaler
// Free-running prescaler that marks every (div+1)-th enabled cycle.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears the prescaler
//   en   - advance enable; 0 freezes the prescaler
//   clr  - synchronous clear; wins over en and suppresses the tick
//   div  - terminal value; the period is div+1 enabled cycles
//   tick - advance strobe for the edge that ends the current period.
//          The parent registers it, so its own tick output changes on
//          the same edge as the count.
module tick_prescaler #(
  parameter int PRE_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             terminal;

  // Greater-or-equal rather than equality: if div is lowered below the
  // current count, the period ends on the next enabled edge instead of
  // running all the way around the counter.
  assign terminal = (pre_q >= div);
  assign tick     = en & ~clr & terminal;

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = terminal ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prescaled_scan_counter.sv
// prescaled_scan_counter
// Up/down scan counter advanced by a programmable prescaler, with a
// one-hot select decode of the count.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   en       - advance enable; 0 freezes prescaler and count
//   div      - prescaler terminal value (tick every div+1 enabled cycles)
//   max      - count terminal value; count range is 0..max
//   up       - direction, 1 = up, 0 = down
//   load     - synchronous load strobe, independent of en
//   load_val - value loaded into count, saturated at max
//   count    - registered scan count
//   tick     - registered pulse on each edge where count advances
//   wrap     - registered pulse on each edge where count wraps
//   sel      - one-hot decode of count
module prescaled_scan_counter
  import prescaled_scan_counter_pkg::*;
#(
  parameter int PRE_W = 20,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRE_W-1:0]      div,
  input  logic [CNT_W-1:0]      max,
  input  logic                  up,
  input  logic                  load,
  input  logic [CNT_W-1:0]      load_val,
  output logic [CNT_W-1:0]      count,
  output logic                  tick,
  output logic                  wrap,
  output logic [(2**CNT_W)-1:0] sel
);

  localparam int NSEL = 2**CNT_W;

  logic             advance;
  step_e            step;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  // Load doubles as the prescaler clear, so a load restarts the period.
  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .div  (div),
    .tick (advance)
  );

  // Load has priority over a simultaneous advance. up is sampled only
  // when an advance happens, so changing it between ticks is harmless.
  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (advance) begin
      step = up ? STEP_UP : STEP_DOWN;
    end
  end

  // Counting down from above max, which happens after max is lowered,
  // lands on max without flagging a wrap. Counting up from at or above
  // max wraps to zero.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    case (step)
      STEP_LOAD: begin
        count_d = (load_val > max) ? max : load_val;
      end
      STEP_UP: begin
        tick_d = 1'b1;
        if (count_q >= max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      STEP_DOWN: begin
        tick_d = 1'b1;
        if (count_q == '0) begin
          count_d = max;
          wrap_d  = 1'b1;
        end else if (count_q > max) begin
          count_d = max;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // Decoded from the count register alone, so sel only changes right
  // after a clock edge or an asynchronous reset.
  always_comb begin
    sel          = '0;
    sel[count_q] = 1'b1;
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_prescaled_scan_counter.sv
// Testbench for prescaled_scan_counter (PRE_W=5, CNT_W=3).
// A behavioural model tracks the prescale position and the count as
// plain integers and predicts count/tick/wrap/sel after every edge.
module tb_prescaled_scan_counter;

  localparam int PRE_W = 5;
  localparam int CNT_W = 3;
  localparam int NSEL  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [PRE_W-1:0] div;
  logic [CNT_W-1:0] max;
  logic             up;
  logic             load;
  logic [CNT_W-1:0] loadVal;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             wrap;
  logic [NSEL-1:0]  sel;

  int checks = 0;
  int errors = 0;

  int mPre;
  int mCount;
  int mTick;
  int mWrap;

  prescaled_scan_counter #(
    .PRE_W (PRE_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div      (div),
    .max      (max),
    .up       (up),
    .load     (load),
    .load_val (loadVal),
    .count    (count),
    .tick     (tick),
    .wrap     (wrap),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [NSEL-1:0] expSel;
    expSel = '0;
    expSel[mCount] = 1'b1;
    checkOutput({tag, ".count"}, 32'(count), 32'(mCount));
    checkOutput({tag, ".tick"},  32'(tick),  32'(mTick));
    checkOutput({tag, ".wrap"},  32'(wrap),  32'(mWrap));
    checkOutput({tag, ".sel"},   32'(sel),   32'(expSel));
  endtask

  // One clock: predict from the current inputs, take the edge, compare.
  task automatic stepCycle(input string tag);
    int nPre, nCount, nTick, nWrap;
    int iMax;
    nPre   = mPre;
    nCount = mCount;
    nTick  = 0;
    nWrap  = 0;
    iMax   = int'(max);
    if (load) begin
      nPre   = 0;
      nCount = (int'(loadVal) > iMax) ? iMax : int'(loadVal);
    end else if (en) begin
      if (mPre >= int'(div)) begin
        nPre  = 0;
        nTick = 1;
        if (up) begin
          if (mCount >= iMax) begin
            nCount = 0;
            nWrap  = 1;
          end else begin
            nCount = mCount + 1;
          end
        end else begin
          if (mCount == 0) begin
            nCount = iMax;
            nWrap  = 1;
          end else if (mCount > iMax) begin
            nCount = iMax;
          end else begin
            nCount = mCount - 1;
          end
        end
      end else begin
        nPre = mPre + 1;
      end
    end
    @(posedge clk);
    #1;
    mPre   = nPre;
    mCount = nCount;
    mTick  = nTick;
    mWrap  = nWrap;
    checkAll(tag);
  endtask

  task automatic applyStimulus(input logic iEn, input int iDiv, input int iMax,
                               input logic iUp, input logic iLoad, input int iLv,
                               input int cycles, input string tag);
    en      = iEn;
    div     = PRE_W'(iDiv);
    max     = CNT_W'(iMax);
    up      = iUp;
    load    = iLoad;
    loadVal = CNT_W'(iLv);
    for (int i = 0; i < cycles; i++) stepCycle(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulseReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    mPre   = 0;
    mCount = 0;
    mTick  = 0;
    mWrap  = 0;
    checkOutput({tag, ".count"}, 32'(count), 32'd0);
    checkOutput({tag, ".sel"},   32'(sel),   32'h01);
    checkOutput({tag, ".tick"},  32'(tick),  32'd0);
    checkOutput({tag, ".wrap"},  32'(wrap),  32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int seq34 [7];
    int guard;
    seq34 = '{4, 3, 2, 1, 0, 4, 3};

    rst = 1'b1; en = 1'b0; div = '0; max = '0; up = 1'b1; load = 1'b0; loadVal = '0;
    mPre = 0; mCount = 0; mTick = 0; mWrap = 0;
    #12;
    checkOutput("reset.count", 32'(count), 32'd0);
    checkOutput("reset.sel",   32'(sel),   32'h01);
    checkOutput("reset.tick",  32'(tick),  32'd0);
    checkOutput("reset.wrap",  32'(wrap),  32'd0);
    rst = 1'b0;

    // div=3, max=7 up: first tick on the 4th enabled edge, full scan + wrap
    applyStimulus(1'b1, 3, 7, 1'b1, 1'b0, 0, 3, "scan");
    applyStimulus(1'b1, 3, 7, 1'b1, 1'b0, 0, 1, "scan");
    checkOutput("firstTick.count", 32'(count), 32'd1);
    checkOutput("firstTick.tick",  32'(tick),  32'd1);
    applyStimulus(1'b1, 3, 7, 1'b1, 1'b0, 0, 32, "scan");

    // div=0, max=4 down from 0
    applyStimulus(1'b0, 0, 4, 1'b0, 1'b1, 0, 1, "load34");
    en = 1'b1; load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      stepCycle("down");
      checkOutput("seq34.count", 32'(count), 32'(seq34[i]));
      checkOutput("seq34.wrap",  32'(wrap),  (seq34[i] == 4) ? 32'd1 : 32'd0);
    end

    // max lowered below count, up then down
    applyStimulus(1'b0, 1, 7, 1'b1, 1'b1, 6, 1, "load35");
    applyStimulus(1'b1, 1, 2, 1'b1, 1'b0, 0, 2, "shrinkUp");
    checkOutput("shrinkUp.count", 32'(count), 32'd0);
    checkOutput("shrinkUp.wrap",  32'(wrap),  32'd1);
    applyStimulus(1'b0, 1, 7, 1'b1, 1'b1, 6, 1, "load35b");
    applyStimulus(1'b1, 1, 2, 1'b0, 1'b0, 0, 2, "shrinkDn");
    checkOutput("shrinkDn.count", 32'(count), 32'd2);
    checkOutput("shrinkDn.wrap",  32'(wrap),  32'd0);

    // load on the same cycle as a pending tick
    applyStimulus(1'b1, 3, 7, 1'b1, 1'b0, 0, 1, "pend");
    guard = 0;
    while (mPre != 3 && guard < 10) begin
      stepCycle("pend");
      guard++;
    end
    checkOutput("pend.reached", 32'(mPre), 32'd3);
    applyStimulus(1'b1, 3, 3, 1'b1, 1'b1, 5, 1, "loadOverTick");
    checkOutput("loadOverTick.count", 32'(count), 32'd3);
    checkOutput("loadOverTick.tick",  32'(tick),  32'd0);
    applyStimulus(1'b1, 3, 3, 1'b1, 1'b0, 0, 3, "afterLoad");
    checkOutput("afterLoad.noTick", 32'(tick), 32'd0);
    applyStimulus(1'b1, 3, 3, 1'b1, 1'b0, 0, 1, "afterLoad");
    checkOutput("afterLoad.tick", 32'(tick), 32'd1);

    // en low for 10 cycles mid-period
    applyStimulus(1'b1, 5, 7, 1'b1, 1'b0, 0, 2, "preFreeze");
    applyStimulus(1'b0, 5, 7, 1'b1, 1'b0, 0, 10, "freeze");
    applyStimulus(1'b1, 5, 7, 1'b1, 1'b0, 0, 8, "resume");

    // async reset with count=5
    applyStimulus(1'b1, 2, 7, 1'b1, 1'b1, 5, 1, "load5");
    checkOutput("load5.count", 32'(count), 32'd5);
    load = 1'b0;
    pulseReset("asyncRst");
    applyStimulus(1'b1, 2, 7, 1'b1, 1'b0, 0, 6, "postRst");

    // randomized run
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) div = PRE_W'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) max = CNT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)  up  = ~up;
      en      = ($urandom_range(0, 4) != 0);
      load    = ($urandom_range(0, 24) == 0);
      loadVal = CNT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) pulseReset("rndRst");
      stepCycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
